// File: rtl/dsdl_pkg.sv
// Shared definitions for the dual binary-to-BCD converter: digit width,
// shift-counter width, the controller state encoding and the per-nibble
// add-3 correction used by every double-dabble lane.
package dsdl_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Width of the shared shift counter; it only has to count 0..IN_W-1 and
  // operands are at most 7 bits wide, so 3 bits always suffice.
  localparam int CNT_W = 3;

  // Width of the BCD scratch register held by each lane (tens + ones).
  localparam int SCRATCH_W = 2 * BCD_W;

  // Controller states: waiting for operands, shifting, publishing digits.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  // Double-dabble correction step: any BCD nibble that is 5 or more gets 3
  // added, so that the following left shift carries correctly into the next
  // decimal digit. The compare is done on the 4-bit nibble as unsigned.
  function automatic logic [SCRATCH_W-1:0] bcd_adj8(input logic [SCRATCH_W-1:0] scratch);
    logic [BCD_W-1:0] onesNib;
    logic [BCD_W-1:0] tensNib;
    onesNib = scratch[BCD_W-1:0];
    tensNib = scratch[SCRATCH_W-1:BCD_W];
    if (onesNib >= 4'd5) begin
      onesNib = onesNib + 4'd3;
    end
    if (tensNib >= 4'd5) begin
      tensNib = tensNib + 4'd3;
    end
    return {tensNib, onesNib};
  endfunction

endpackage

// File: rtl/bcd_dabble_lane.sv
// One operand lane of the dual converter. It saturates the incoming binary
// operand, runs the shift-add-3 sequence one bit per shift strobe, and
// publishes the finished tens/ones digits plus the saturation flag on the
// commit strobe. The lane has no sequencing of its own; the shared controller
// in the top module decides when to load, shift and commit.
module bcd_dabble_lane
  import dsdl_pkg::*;
#(
  parameter int IN_W    = 7,
  parameter int MAX_VAL = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             commit,
  input  logic [IN_W-1:0]  bin,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             sat
);

  // Saturation ceiling expressed at operand width, so the compare and the
  // substitution below stay width-matched.
  localparam logic [IN_W-1:0] MAX_OP = IN_W'(MAX_VAL);

  // Remaining binary bits still to be shifted into the BCD scratch.
  logic [IN_W-1:0]      opReg;
  // Partially converted BCD value (tens nibble above ones nibble).
  logic [SCRATCH_W-1:0] scratchReg;
  // Saturation flag of the conversion in flight.
  logic                 satReg;
  // Scratch value after the add-3 correction, ready to be shifted.
  logic [SCRATCH_W-1:0] adjusted;
  // Whether the operand presented at load exceeds the ceiling.
  logic                 overLimit;

  // Combinational correction and saturation decision feeding the registers.
  assign adjusted  = bcd_adj8(scratchReg);
  assign overLimit = (bin > MAX_OP);

  // Working registers: capture the clamped operand on load, then on each
  // shift move the top operand bit into the corrected scratch. Shifting the
  // concatenation lets the bit that falls off the scratch top simply drop,
  // which is safe because a clamped operand never needs a hundreds digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg      <= '0;
      scratchReg <= '0;
      satReg     <= 1'b0;
    end else if (load) begin
      satReg     <= overLimit;
      opReg      <= overLimit ? MAX_OP : bin;
      scratchReg <= '0;
    end else if (shift) begin
      {scratchReg, opReg} <= {adjusted, opReg} << 1;
    end
  end

  // Published digits and flag: they only move on commit so the downstream
  // seven-segment decoder always sees a complete, stable result.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
      sat  <= 1'b0;
    end else if (commit) begin
      tens <= scratchReg[SCRATCH_W-1:BCD_W];
      ones <= scratchReg[BCD_W-1:0];
      sat  <= satReg;
    end
  end

endmodule

// File: rtl/dual_bcd_converter.sv
// Dual binary-to-BCD converter feeding the HEX7..HEX4 seven-segment path.
// Two operands are accepted together, each clamped to MAX_VAL and converted
// to tens/ones digits by an iterative double-dabble lane. A single shared
// controller sequences both lanes: IDLE accepts, SHIFT runs IN_W correction
// and shift steps, DONE publishes the digits and raises a one-cycle
// out_valid pulse. One conversion completes every IN_W+2 cycles at most.
module dual_bcd_converter
  import dsdl_pkg::*;
#(
  parameter int IN_W    = 7,
  parameter int MAX_VAL = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a_bin,
  input  logic [IN_W-1:0]  b_bin,
  output logic             out_valid,
  output logic [BCD_W-1:0] a_tens,
  output logic [BCD_W-1:0] a_ones,
  output logic [BCD_W-1:0] b_tens,
  output logic [BCD_W-1:0] b_ones,
  output logic             a_sat,
  output logic             b_sat
);

  // Counter value on the final shift step of a conversion.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  // Controller state and its combinational successor.
  state_e           state;
  state_e           stateNext;
  // Shift step index within the current conversion.
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  // Strobes that drive both lanes in lockstep.
  logic             loadStrobe;
  logic             shiftStrobe;
  logic             commitStrobe;

  // Controller registers: reset always wins, which also aborts a conversion
  // that is part-way through shifting or waiting to commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state and strobe decode. Inputs are only looked at in IDLE, so
  // operand changes during a conversion are ignored rather than queued.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    in_ready     = 1'b0;
    loadStrobe   = 1'b0;
    shiftStrobe  = 1'b0;
    commitStrobe = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          loadStrobe = 1'b1;
          cntNext    = '0;
          stateNext  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shiftStrobe = 1'b1;
        if (cnt == CNT_LAST) begin
          stateNext = S_DONE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        commitStrobe = 1'b1;
        stateNext    = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

  // out_valid marks the cycle in which freshly committed digits first appear.
  // DONE always leads straight back to IDLE, so the pulse is never two long.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= commitStrobe;
    end
  end

  // Operand A lane (switches SW[17:11]).
  bcd_dabble_lane #(
    .IN_W    (IN_W),
    .MAX_VAL (MAX_VAL)
  ) laneA (
    .clk    (clk),
    .rst    (rst),
    .load   (loadStrobe),
    .shift  (shiftStrobe),
    .commit (commitStrobe),
    .bin    (a_bin),
    .tens   (a_tens),
    .ones   (a_ones),
    .sat    (a_sat)
  );

  // Operand B lane (switches SW[10:4]).
  bcd_dabble_lane #(
    .IN_W    (IN_W),
    .MAX_VAL (MAX_VAL)
  ) laneB (
    .clk    (clk),
    .rst    (rst),
    .load   (loadStrobe),
    .shift  (shiftStrobe),
    .commit (commitStrobe),
    .bin    (b_bin),
    .tens   (b_tens),
    .ones   (b_ones),
    .sat    (b_sat)
  );

endmodule
